tron_turn_scheduler: RTL

Game sequencer for the two-player light-cycle grid. On every game tick it updates both players' positions from their direction inputs. It then presents each position to the grid block in turn with a one-cycle player strobe, waits one settle cycle, and samples the grid's collision flags to decide whether the game continues or ends. It sits between the joystick/direction logic and the grid datapath, and feeds the display/score logic.

---
 rtl/tron_turn_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tron_turn_scheduler.sv
// tron_turn_scheduler: per-tick game sequencer for the two-player light-cycle grid.
// Optional build macro WALL_BOUNDARY_EN makes grid edges lethal instead of wrapping.
module tron_turn_scheduler #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 64,
    parameter int TICK_DIV = 50000,
    parameter int TICK_W   = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  dir_p1,
    input  logic [1:0]  dir_p2,
    input  logic        hit_one,
    input  logic        hit_two,
    input  logic        is_crash,
    output logic [31:0] play_x,
    output logic [31:0] play_y,
    output logic        is_play_one,
    output logic        is_play_two,
    output logic [1:0]  game_state,
    output logic [1:0]  winner,
    output logic [15:0] moves
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_MOVE1, S_MOVE2, S_SETTLE, S_CHECK, S_OVER
    } state_t;

    localparam logic [5:0]        X_MAX     = 6'(GRID_W - 1);
    localparam logic [5:0]        Y_MAX     = 6'(GRID_H - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef WALL_BOUNDARY_EN
    localparam int SW = 13;
    // Result is {out_of_bounds, x, y}; an illegal move leaves the position unchanged.
    function automatic logic [SW-1:0] step(input logic [5:0] x, input logic [5:0] y,
                                           input logic [1:0] d);
        logic       oob;
        logic [5:0] nx, ny;
        oob = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            2'b00:   if (y == 6'd0)  oob = 1'b1; else ny = y - 6'd1;
            2'b01:   if (x == X_MAX) oob = 1'b1; else nx = x + 6'd1;
            2'b10:   if (y == Y_MAX) oob = 1'b1; else ny = y + 6'd1;
            default: if (x == 6'd0)  oob = 1'b1; else nx = x - 6'd1;
        endcase
        return {oob, nx, ny};
    endfunction
`else
    localparam int SW = 12;
    function automatic logic [SW-1:0] step(input logic [5:0] x, input logic [5:0] y,
                                           input logic [1:0] d);
        logic [5:0] nx, ny;
        nx = x;
        ny = y;
        case (d)
            2'b00:   ny = (y == 6'd0)  ? Y_MAX : y - 6'd1;
            2'b01:   nx = (x == X_MAX) ? 6'd0  : x + 6'd1;
            2'b10:   ny = (y == Y_MAX) ? 6'd0  : y + 6'd1;
            default: nx = (x == 6'd0)  ? X_MAX : x - 6'd1;
        endcase
        return {nx, ny};
    endfunction
`endif

    state_t            state_q;
    logic [TICK_W-1:0] cnt_q;
    logic [5:0]        p1x_q, p1y_q, p2x_q, p2y_q, px_q, py_q;
    logic [1:0]        d1_q, d2_q, gs_q, win_q;
    logic              one_q, two_q;
    logic [15:0]       moves_q;
    logic [1:0]        d1_d, d2_d;
    logic [SW-1:0]     s1_d, s2_d;
    logic              h1_d, h2_d;

    // Encoding places the reverse of any direction at d ^ 2'b10.
    assign d1_d = (dir_p1 == (d1_q ^ 2'b10)) ? d1_q : dir_p1;
    assign d2_d = (dir_p2 == (d2_q ^ 2'b10)) ? d2_q : dir_p2;
    assign s1_d = step(p1x_q, p1y_q, d1_d);
    assign s2_d = step(p2x_q, p2y_q, d2_d);

`ifdef WALL_BOUNDARY_EN
    logic oob1_q, oob2_q;
    assign h1_d = hit_one | oob1_q;
    assign h2_d = hit_two | oob2_q;
`else
    assign h1_d = hit_one;
    assign h2_d = hit_two;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p1x_q   <= '0;
            p1y_q   <= '0;
            p2x_q   <= '0;
            p2y_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            gs_q    <= '0;
            win_q   <= '0;
            one_q   <= 1'b0;
            two_q   <= 1'b0;
            moves_q <= '0;
`ifdef WALL_BOUNDARY_EN
            oob1_q  <= 1'b0;
            oob2_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        gs_q    <= 2'b01;
                        win_q   <= '0;
                        moves_q <= '0;
                    end
                end
                S_LOAD: begin
                    p1x_q   <= 6'(GRID_W / 4);
                    p1y_q   <= 6'(GRID_H / 2);
                    p2x_q   <= 6'(3 * GRID_W / 4);
                    p2y_q   <= 6'(GRID_H / 2);
                    d1_q    <= 2'b01;
                    d2_q    <= 2'b11;
                    cnt_q   <= '0;
                    win_q   <= '0;
                    moves_q <= '0;
`ifdef WALL_BOUNDARY_EN
                    oob1_q  <= 1'b0;
                    oob2_q  <= 1'b0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == TICK_LAST) begin
                        cnt_q   <= '0;
                        d1_q    <= d1_d;
                        d2_q    <= d2_d;
                        p1x_q   <= s1_d[11:6];
                        p1y_q   <= s1_d[5:0];
                        p2x_q   <= s2_d[11:6];
                        p2y_q   <= s2_d[5:0];
                        px_q    <= s1_d[11:6];
                        py_q    <= s1_d[5:0];
`ifdef WALL_BOUNDARY_EN
                        oob1_q  <= s1_d[12];
                        oob2_q  <= s2_d[12];
                        one_q   <= ~s1_d[12];
`else
                        one_q   <= 1'b1;
`endif
                        state_q <= S_MOVE1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_MOVE1: begin
                    one_q   <= 1'b0;
                    px_q    <= p2x_q;
                    py_q    <= p2y_q;
`ifdef WALL_BOUNDARY_EN
                    two_q   <= ~oob2_q;
`else
                    two_q   <= 1'b1;
`endif
                    state_q <= S_MOVE2;
                end
                S_MOVE2: begin
                    two_q   <= 1'b0;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: state_q <= S_CHECK;
                S_CHECK: begin
                    if (is_crash || (h1_d && h2_d)) begin
                        win_q   <= 2'b11;
                        gs_q    <= 2'b10;
                        state_q <= S_OVER;
                    end else if (h1_d) begin
                        win_q   <= 2'b10;
                        gs_q    <= 2'b10;
                        state_q <= S_OVER;
                    end else if (h2_d) begin
                        win_q   <= 2'b01;
                        gs_q    <= 2'b10;
                        state_q <= S_OVER;
                    end else begin
                        if (moves_q != 16'hFFFF) moves_q <= moves_q + 16'd1;
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign play_x      = {26'd0, px_q};
    assign play_y      = {26'd0, py_q};
    assign is_play_one = one_q;
    assign is_play_two = two_q;
    assign game_state  = gs_q;
    assign winner      = win_q;
    assign moves       = moves_q;
endmodule
